regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 register file. Merges two writeback sources, a fixed-latency ALU path (A) and a long-latency load/divide path (B, buffered), onto the register file's single write port (wt_addr, wt_data, reg_write). It also tracks registers with outstanding long-latency results and raises a stall to the issue stage on RAW/WAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the ALU writeback path (A) and the buffered
// long-latency path (B) onto the single register-file write port, and keeps
// a pending-register scoreboard that stalls issue on RAW/WAW hazards.
//
// Handshake: a request transfers on a clock edge where valid and ready are
// both high; ready never depends on valid of the same port, and a requester
// holds its payload stable until the transfer edge.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_addr,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    input  logic [4:0]      iss_rd,
    input  logic            iss_long,
    output logic            stall,
    output logic [4:0]      wt_addr,
    output logic [XLEN-1:0] wt_data,
    output logic            reg_write,
    output logic            sb_err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    // B-path FIFO storage and pointers
    logic [4:0]      addr_mem [BUF_DEPTH];
    logic [XLEN-1:0] data_mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STV_W-1:0] starve_q, starve_d;

    // Scoreboard: bit 0 is tied low, x0 is never pending
    logic [31:0] pend_q, pend_d;
    logic        sb_err_q, sb_err_d;

    // Registered write port
    logic [4:0]      wt_addr_q;
    logic [XLEN-1:0] wt_data_q;
    logic            reg_write_q, src_b_q;

    logic fifo_empty, fifo_full, force_b, a_win, b_win, push, pop;
    logic rs1_hit, rs2_hit, rd_hit, iss_set, wb_clr;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    // B is forced only once its head has lost STARVE_LIMIT cycles in a row
    assign force_b    = !fifo_empty && (starve_q == STV_MAX);

    assign a_ready = !rst && !force_b;
    assign b_ready = !rst && !fifo_full;

    assign a_win = a_valid && a_ready;
    assign b_win = !a_win && !fifo_empty;
    assign push  = b_valid && b_ready;
    assign pop   = b_win;

    assign rs1_hit = (iss_rs1 != 5'd0) && pend_q[iss_rs1];
    assign rs2_hit = (iss_rs2 != 5'd0) && pend_q[iss_rs2];
    assign rd_hit  = (iss_rd  != 5'd0) && pend_q[iss_rd];
    assign stall   = !rst && iss_valid && (rs1_hit || rs2_hit || rd_hit);

    assign iss_set = iss_valid && !stall && iss_long && (iss_rd != 5'd0);
    // reg_write already implies a non-zero address
    assign wb_clr  = reg_write_q && src_b_q;

    assign wt_addr   = wt_addr_q;
    assign wt_data   = wt_data_q;
    assign reg_write = reg_write_q;
    assign sb_err    = sb_err_q;

    // Next-state for FIFO bookkeeping, starvation counter and scoreboard
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        pend_d   = pend_q;
        sb_err_d = sb_err_q;

        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);

        if (fifo_empty || b_win)    starve_d = '0;
        else if (starve_q != STV_MAX) starve_d = starve_q + STV_W'(1);

        if (wb_clr) begin
            pend_d[wt_addr_q] = 1'b0;
            if (!pend_q[wt_addr_q]) sb_err_d = 1'b1;
        end
        if (iss_set) pend_d[iss_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // State registers and the registered write port, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            pend_q      <= '0;
            sb_err_q    <= 1'b0;
            wt_addr_q   <= '0;
            wt_data_q   <= '0;
            reg_write_q <= 1'b0;
            src_b_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
            if (a_win) begin
                wt_addr_q   <= a_addr;
                wt_data_q   <= a_data;
                reg_write_q <= (a_addr != 5'd0);
                src_b_q     <= 1'b0;
            end else if (b_win) begin
                wt_addr_q   <= addr_mem[rd_ptr_q];
                wt_data_q   <= data_mem[rd_ptr_q];
                reg_write_q <= (addr_mem[rd_ptr_q] != 5'd0);
                src_b_q     <= 1'b1;
            end else begin
                reg_write_q <= 1'b0;
                src_b_q     <= 1'b0;
            end
        end
    end

    // FIFO payload; contents are only observable through valid pointers
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= b_addr;
            data_mem[wr_ptr_q] <= b_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1 time unit after the
// rising edge, outputs are sampled 1 time unit after inputs settle.
module tb_regfile_wb_arbiter;

    logic        clk, rst;
    logic        a_valid, b_valid, iss_valid, iss_long;
    logic [4:0]  a_addr, b_addr, iss_rs1, iss_rs2, iss_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, stall, reg_write, sb_err;
    logic [4:0]  wt_addr;
    logic [31:0] wt_data;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.XLEN(32), .BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_long(iss_long), .stall(stall),
        .wt_addr(wt_addr), .wt_data(wt_data), .reg_write(reg_write),
        .sb_err(sb_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_long = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rd, input logic lng);
        iss_valid = 1; iss_rs1 = rs1; iss_rs2 = 0; iss_rd = rd; iss_long = lng;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        rst = 1;
        // reset state
        #2;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_wt_addr", wt_addr, 0);
        chk("rst_wt_data", wt_data, 0);
        chk("rst_sb_err", sb_err, 0);
        tick(); tick();
        rst = 0;
        #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 1);

        // address 0: consumed, no write, data still captured
        a_valid = 1; a_addr = 0; a_data = 32'hFFFF_FFFF;
        #1 chk("x0_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        #1;
        chk("x0_reg_write", reg_write, 0);
        chk("x0_wt_data", wt_data, 32'hFFFF_FFFF);
        issue(0, 0, 1);
        #1 chk("x0_long_stall", stall, 0);
        tick();
        issue(0, 0, 0);
        #1 chk("x0_rs1_stall", stall, 0);
        tick();

        // RAW on long-latency rd=7
        issue(0, 7, 1);
        #1 chk("l7_issue_stall", stall, 0);
        tick();
        issue(7, 1, 0);
        b_valid = 1; b_addr = 7; b_data = 32'hDEAD_BEEF;
        #1;
        chk("l7_raw_stall", stall, 1);
        chk("l7_b_ready", b_ready, 1);
        tick();                         // push edge
        b_valid = 0;
        #1;
        chk("l7_c1_stall", stall, 1);
        chk("l7_c1_reg_write", reg_write, 0);
        tick();                         // grant edge
        #1;
        chk("l7_c2_reg_write", reg_write, 1);
        chk("l7_c2_wt_addr", wt_addr, 7);
        chk("l7_c2_wt_data", wt_data, 32'hDEAD_BEEF);
        chk("l7_c2_stall", stall, 1);
        tick();                         // pend clear edge
        #1;
        chk("l7_c3_stall", stall, 0);
        chk("l7_c3_reg_write", reg_write, 0);
        chk("l7_c3_sb_err", sb_err, 0);
        idle();
        tick();

        // starvation: A held high, one B entry for x3
        issue(0, 3, 1);
        tick();
        idle();
        for (int k = 0; k < 7; k++) begin
            a_valid = 1; a_addr = 5'(10 + k); a_data = 32'hA0 + k;
            b_valid = (k == 0); b_addr = 3; b_data = 32'h11;
            #1;
            chk($sformatf("stv_a_ready_%0d", k), a_ready, (k == 5) ? 0 : 1);
            tick();
            chk($sformatf("stv_reg_write_%0d", k), reg_write, 1);
            chk($sformatf("stv_wt_addr_%0d", k), wt_addr, (k == 5) ? 3 : 10 + k);
            chk($sformatf("stv_wt_data_%0d", k), wt_data, (k == 5) ? 32'h11 : 32'hA0 + k);
        end
        idle();
        tick();
        chk("stv_sb_err", sb_err, 0);

        // FIFO full with A high; third B request held until after a pop
        issue(0, 20, 1); tick();
        issue(0, 21, 1); tick();
        issue(0, 22, 1); tick();
        idle();
        a_valid = 1; a_addr = 12; a_data = 32'hC;
        b_valid = 1; b_addr = 20; b_data = 32'h2020;
        #1 chk("full_f0_b_ready", b_ready, 1);
        tick();
        b_addr = 21; b_data = 32'h2121;
        #1 chk("full_f1_b_ready", b_ready, 1);
        tick();
        b_addr = 22; b_data = 32'h2222;
        #1 chk("full_f2_b_ready", b_ready, 0);
        tick();
        #1 chk("full_f3_b_ready", b_ready, 0);
        tick();
        tick();
        #1;
        chk("full_f5_a_ready", a_ready, 0);
        chk("full_f5_b_ready", b_ready, 0);
        tick();
        #1;
        chk("full_f6_wt_addr", wt_addr, 20);
        chk("full_f6_wt_data", wt_data, 32'h2020);
        chk("full_f6_b_ready", b_ready, 1);
        chk("full_f6_a_ready", a_ready, 1);
        tick();
        a_valid = 0; b_valid = 0;
        #1 chk("full_f7_wt_addr", wt_addr, 12);
        tick();
        #1;
        chk("full_f8_wt_addr", wt_addr, 21);
        chk("full_f8_wt_data", wt_data, 32'h2121);
        tick();
        #1;
        chk("full_f9_wt_addr", wt_addr, 22);
        chk("full_f9_wt_data", wt_data, 32'h2222);
        tick();
        #1;
        chk("full_f10_reg_write", reg_write, 0);
        chk("full_f10_wt_addr", wt_addr, 22);
        chk("full_f10_sb_err", sb_err, 0);

        // B write to non-pending x9 sets sticky error
        b_valid = 1; b_addr = 9; b_data = 32'h99;
        tick();
        b_valid = 0;
        tick();
        #1;
        chk("err_reg_write", reg_write, 1);
        chk("err_wt_addr", wt_addr, 9);
        chk("err_before", sb_err, 0);
        tick();
        #1 chk("err_set", sb_err, 1);
        tick(); tick();
        #1 chk("err_sticky", sb_err, 1);

        // reset mid-stream: two queued B entries and pend[5]
        issue(0, 5, 1); tick();
        idle();
        a_valid = 1; a_addr = 13; a_data = 32'h13;
        b_valid = 1; b_addr = 5; b_data = 32'h55; tick();
        b_addr = 6; b_data = 32'h66; tick();
        b_valid = 0;
        issue(5, 0, 0);
        #1;
        chk("mid_b_ready_full", b_ready, 0);
        chk("mid_stall_pend5", stall, 1);
        #1 rst = 1;
        #1;
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_b_ready", b_ready, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_reg_write", reg_write, 0);
        chk("mid_rst_sb_err", sb_err, 0);
        tick();
        rst = 0;
        a_valid = 0;
        #1;
        chk("after_b_ready", b_ready, 1);
        chk("after_stall_rs5", stall, 0);
        chk("after_wt_addr", wt_addr, 0);
        tick();
        #1;
        chk("after_reg_write", reg_write, 0);
        chk("after_sb_err", sb_err, 0);
        tick();
        #1 chk("after_reg_write2", reg_write, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
